nand_input_debounce: RTL and testbench

- Input-conditioning stage that sits directly upstream of the NAND gate block.
- Takes raw, asynchronous push-button or switch levels from the dedicated input pins, synchronises them into the clock domain and debounces each channel.
- Drives clean levels (dout) into the NAND operands; also provides single-cycle rise/fall pulses for later counters or loggers.

---
 rtl/nand_input_debounce.sv | 81 ++++++++
 tb/tb_nand_input_debounce.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/nand_input_debounce.sv
// Purpose: synchronise and debounce raw button/switch levels that feed the NAND gate operands.
// Latency: a stable input change reaches dout DEBOUNCE_CYCLES+1 edges after it is first captured.
// Backpressure: none; free-running conditioner, ena=0 freezes the debounce state and mutes pulses.
//
// Ports:
//   clk    - system clock, all state updates on the rising edge
//   rst_n  - synchronous active-low reset, clears every flop regardless of ena
//   ena    - 1 = debounce runs, 0 = counters and dout hold (synchroniser keeps running)
//   din    - raw asynchronous inputs, one bit per channel (0 = A, 1 = B)
//   dout   - debounced levels driving the NAND operands
//   rise   - one-cycle pulse coincident with the first cycle of a 0->1 dout change
//   fall   - one-cycle pulse coincident with the first cycle of a 1->0 dout change
//   busy   - high while any channel counter is non-zero (a change is being qualified)
module nand_input_debounce #(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             busy
);

   // Counter value on which the disagreement is accepted; counting never goes past it.
   localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [CNT_W-1:0] cnt [WIDTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1   <= '0;
         s2   <= '0;
         dout <= '0;
         rise <= '0;
         fall <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         // Two-flop synchroniser runs even while frozen so no stale level is
         // held in the sync chain when ena comes back.
         s1   <= din;
         s2   <= s1;
         // Pulses are single-cycle by default; only a terminal count sets them.
         rise <= '0;
         fall <= '0;
         if (ena) begin
            for (int i = 0; i < WIDTH; i++) begin
               if (s2[i] == dout[i]) begin
                  // Agreement (or a glitch that settled back) restarts qualification.
                  cnt[i] <= '0;
               end else if (cnt[i] >= TERM) begin
                  dout[i] <= s2[i];
                  rise[i] <= s2[i];
                  fall[i] <= ~s2[i];
                  cnt[i]  <= '0;
               end else begin
                  cnt[i] <= cnt[i] + CNT_W'(1);
               end
            end
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (cnt[i] != '0) begin
            busy = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nand_input_debounce.sv
module tb_nand_input_debounce;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [1:0] din;
   logic [1:0] dout;
   logic [1:0] rise;
   logic [1:0] fall;
   logic       busy;

   nand_input_debounce #(
      .WIDTH           (2),
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .din   (din),
      .dout  (dout),
      .rise  (rise),
      .fall  (fall),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Number of rising edges seen so far; outputs are sampled on the falling edge.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [1:0] dout;
      logic [1:0] rise;
      logic [1:0] fall;
      logic       busy;
      logic       nand_o;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic expect_at(input int c, input logic [1:0] d, input logic [1:0] r,
                            input logic [1:0] f, input logic b, input string nm);
      exp_t e;
      e.cyc    = c;
      e.dout   = d;
      e.rise   = r;
      e.fall   = f;
      e.busy   = b;
      e.nand_o = ~(d[0] & d[1]);
      e.name   = nm;
      sb.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: compares the DUT outputs against the scoreboard entry due this
   // cycle; any pulse with no entry due is an unexpected output.
   always @(negedge clk) begin
      exp_t e;
      logic nand_act;
      nand_act = ~(dout[0] & dout[1]);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         vectors++;
         miscompares++;
         $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.name, e.cyc, cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         vectors++;
         if (dout !== e.dout || rise !== e.rise || fall !== e.fall ||
             busy !== e.busy || nand_act !== e.nand_o) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got dout=%b rise=%b fall=%b busy=%b nand=%b, want dout=%b rise=%b fall=%b busy=%b nand=%b",
                     e.name, cyc, dout, rise, fall, busy, nand_act,
                     e.dout, e.rise, e.fall, e.busy, e.nand_o);
         end
      end else if ((rise | fall) != 2'b00) begin
         miscompares++;
         $display("FAIL unexpected_pulse @cyc %0d: got rise=%b fall=%b dout=%b, want rise=00 fall=00",
                  cyc, rise, fall, dout);
      end
   end

   initial begin
      int k;
      rst_n = 1'b0;
      ena   = 1'b1;
      din   = 2'b11;

      // Reset held for two edges with inputs high.
      expect_at(1, 2'b00, 2'b00, 2'b00, 1'b0, "rst_e1");
      expect_at(2, 2'b00, 2'b00, 2'b00, 1'b0, "rst_e2");
      tick(2);
      rst_n = 1'b0;
      rst_n = 1'b1;
      k = cyc;
      // First capture at k+1, s2 at k+2, cnt=1 at k+3, dout at k+6.
      expect_at(k+1, 2'b00, 2'b00, 2'b00, 1'b0, "rel_cap");
      expect_at(k+2, 2'b00, 2'b00, 2'b00, 1'b0, "rel_s2");
      expect_at(k+3, 2'b00, 2'b00, 2'b00, 1'b1, "rel_cnt1");
      expect_at(k+5, 2'b00, 2'b00, 2'b00, 1'b1, "rel_pre");
      expect_at(k+6, 2'b11, 2'b11, 2'b00, 1'b0, "rel_rise");
      expect_at(k+7, 2'b11, 2'b00, 2'b00, 1'b0, "rel_once");
      tick(8);

      // Both channels fall together to get a clean baseline.
      din = 2'b00;
      k = cyc;
      expect_at(k+5, 2'b11, 2'b00, 2'b00, 1'b1, "fall_pre");
      expect_at(k+6, 2'b00, 2'b00, 2'b11, 1'b0, "fall_both");
      tick(8);

      // Clean step on channel A, channel B untouched.
      din = 2'b01;
      k = cyc;
      expect_at(k+5, 2'b00, 2'b00, 2'b00, 1'b1, "step_pre");
      expect_at(k+6, 2'b01, 2'b01, 2'b00, 1'b0, "step_rise");
      expect_at(k+7, 2'b01, 2'b00, 2'b00, 1'b0, "step_once");
      tick(8);
      din = 2'b00;
      k = cyc;
      expect_at(k+5, 2'b01, 2'b00, 2'b00, 1'b1, "stepf_pre");
      expect_at(k+6, 2'b00, 2'b00, 2'b01, 1'b0, "step_fall");
      expect_at(k+7, 2'b00, 2'b00, 2'b00, 1'b0, "stepf_once");
      tick(8);

      // Glitch: three captures high reach cnt=3 (one short of terminal), then clear.
      din = 2'b01;
      k = cyc;
      expect_at(k+5, 2'b00, 2'b00, 2'b00, 1'b1, "glitch_max");
      expect_at(k+6, 2'b00, 2'b00, 2'b00, 1'b0, "glitch_clr");
      expect_at(k+8, 2'b00, 2'b00, 2'b00, 1'b0, "glitch_hold");
      tick(3);
      din = 2'b00;
      tick(8);

      // Freeze: channel B at cnt=2, ena low for 10 edges, then two more edges to dout.
      din = 2'b10;
      k = cyc;
      expect_at(k+4,  2'b00, 2'b00, 2'b00, 1'b1, "frz_cnt2");
      expect_at(k+10, 2'b00, 2'b00, 2'b00, 1'b1, "frz_mid");
      expect_at(k+14, 2'b00, 2'b00, 2'b00, 1'b1, "frz_end");
      expect_at(k+15, 2'b00, 2'b00, 2'b00, 1'b1, "frz_resume");
      expect_at(k+16, 2'b10, 2'b10, 2'b00, 1'b0, "frz_rise");
      expect_at(k+17, 2'b10, 2'b00, 2'b00, 1'b0, "frz_once");
      tick(4);
      ena = 1'b0;
      tick(10);
      ena = 1'b1;
      tick(8);

      // Simultaneous rise on both operands: NAND output drops 1->0 that cycle.
      din = 2'b00;
      k = cyc;
      expect_at(k+6, 2'b00, 2'b00, 2'b10, 1'b0, "sim_base");
      tick(8);
      din = 2'b11;
      k = cyc;
      expect_at(k+5, 2'b00, 2'b00, 2'b00, 1'b1, "sim_pre");
      expect_at(k+6, 2'b11, 2'b11, 2'b00, 1'b0, "sim_rise");
      expect_at(k+7, 2'b11, 2'b00, 2'b00, 1'b0, "sim_once");
      tick(8);

      // Reset while channel A sits at cnt=3; full latency needed again afterwards.
      din = 2'b00;
      k = cyc;
      expect_at(k+6, 2'b00, 2'b00, 2'b11, 1'b0, "rmc_base");
      tick(8);
      din = 2'b01;
      k = cyc;
      expect_at(k+5,  2'b00, 2'b00, 2'b00, 1'b1, "rmc_cnt3");
      expect_at(k+6,  2'b00, 2'b00, 2'b00, 1'b0, "rmc_rst");
      expect_at(k+11, 2'b00, 2'b00, 2'b00, 1'b1, "rmc_pre");
      expect_at(k+12, 2'b01, 2'b01, 2'b00, 1'b0, "rmc_rise");
      expect_at(k+13, 2'b01, 2'b00, 2'b00, 1'b0, "rmc_once");
      tick(5);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(10);

      tick(2);
      if (sb.size() != 0) begin
         miscompares += sb.size();
         $display("FAIL sb_drain: got %0d pending expectations, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
